// File: rtl/mod_operand_fetch.sv
// Operand-fetch stage: scoreboards outstanding register writes and
// registers source operands into the execute latch once hazards clear.
module mod_operand_fetch #(
  parameter int CNT_W = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  output logic              id_ready,
  input  logic [7:0]        id_opcode,
  input  logic              id_twob,
  input  logic [3:0]        id_regByte,
  input  logic [3:0]        id_rmByte,
  input  logic [1:0]        id_mod,
  input  logic [63:0]       id_imm,
  input  logic [0:15][0:63] regfile,
  input  logic              wb_valid,
  input  logic [0:15]       wb_dest_mask,
  input  logic              flush,
  output logic              ex_valid,
  input  logic              ex_ready,
  output logic [7:0]        ex_opcode,
  output logic              ex_twob,
  output logic [3:0]        ex_regByte,
  output logic [3:0]        ex_rmByte,
  output logic [1:0]        ex_mod,
  output logic [63:0]       ex_imm,
  output logic [63:0]       ex_opA,
  output logic [63:0]       ex_opB,
  output logic [63:0]       ex_rsp,
  output logic [0:15]       ex_dest_mask,
  output logic [31:0]       stall_cycles,
  output logic              sb_error
);

  typedef struct packed {
    logic [7:0]  opcode;
    logic        twob;
    logic [3:0]  regb;
    logic [3:0]  rmb;
    logic [1:0]  md;
    logic [63:0] imm;
    logic [63:0] opa;
    logic [63:0] opb;
    logic [63:0] rsp;
    logic [0:15] dmask;
  } ex_t;

  ex_t                    ex_q, ex_d;
  logic                   ex_valid_q, ex_valid_d;
  logic [15:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]            stall_q, stall_d;
  logic                   sb_err_q, sb_err_d;

  logic [0:15] dst, src, busy, full;
  logic        is_push, is_pop, is_call;
  logic        hazard, accept;
  int unsigned c, t;

  always_comb begin
    is_push = id_opcode[7:3] == 5'b01010;
    is_pop  = id_opcode[7:3] == 5'b01011;
    is_call = id_opcode == 8'hFF || id_opcode == 8'hE8 ||
              id_opcode == 8'hC3;
    dst = '0;
    if (id_opcode == 8'h90) begin
      dst = '0;
    end else if (id_opcode == 8'hF7 ||
                 (id_opcode == 8'hAF && id_twob)) begin
      dst[0] = 1'b1;
      dst[2] = 1'b1;
    end else if (id_opcode == 8'h05) begin
      dst[0] = 1'b1;
    end else if (is_call) begin
      dst[4] = 1'b1;
    end else if (id_twob) begin
      dst = '0;
    end else if (is_push) begin
      dst[4] = 1'b1;
    end else if (is_pop) begin
      dst[4] = 1'b1;
      dst[id_rmByte] = 1'b1;
    end else if (id_opcode == 8'h89) begin
      dst[id_rmByte] = id_mod == 2'b11;
    end else if (id_opcode == 8'h8B || id_opcode == 8'h8D) begin
      dst[id_regByte] = 1'b1;
    end else if (id_opcode[7:3] == 5'b10111) begin
      dst[id_rmByte] = 1'b1;
    end else if (id_opcode == 8'h39) begin
      dst = '0;
    end else begin
      dst[id_rmByte] = 1'b1;
    end
    src = '0;
    src[id_regByte] = 1'b1;
    src[id_rmByte] = 1'b1;
    if (is_push || is_pop || is_call) src[4] = 1'b1;
    if (id_opcode == 8'hF7 || id_opcode == 8'h05) src[0] = 1'b1;
  end

  // Hazard uses counters as they stand before this cycle's update.
  always_comb begin
    for (int i = 0; i < 16; i++) begin
      busy[i] = cnt_q[i] != '0;
      full[i] = &cnt_q[i];
    end
    hazard = |((src | dst) & busy) || |(dst & full);
    id_ready = reset && !hazard &&
               (!ex_valid_q || ex_ready || flush);
    accept = id_valid && id_ready;
  end

  always_comb begin
    cnt_d = cnt_q;
    sb_err_d = sb_err_q;
    c = 0;
    t = 0;
    for (int i = 0; i < 16; i++) begin
      c = 32'(cnt_q[i]);
      t = 32'(wb_valid && wb_dest_mask[i]) +
          32'(flush && ex_valid_q && ex_q.dmask[i]);
      if (accept && dst[i]) begin
        if (t == 0) c = c + 1;
        else t = t - 1;
      end
      if (wb_valid && wb_dest_mask[i] && cnt_q[i] == '0 &&
          !(accept && dst[i]))
        sb_err_d = 1'b1;
      c = (c > t) ? c - t : 0;
      cnt_d[i] = CNT_W'(c);
    end
  end

  always_comb begin
    ex_d = ex_q;
    ex_valid_d = ex_valid_q;
    if (accept) begin
      ex_valid_d = 1'b1;
      ex_d.opcode = id_opcode;
      ex_d.twob = id_twob;
      ex_d.regb = id_regByte;
      ex_d.rmb = id_rmByte;
      ex_d.md = id_mod;
      ex_d.imm = id_imm;
      ex_d.opa = regfile[id_regByte];
      ex_d.opb = regfile[id_rmByte];
      ex_d.rsp = regfile[4];
      ex_d.dmask = dst;
    end else if (ex_ready || flush) begin
      ex_valid_d = 1'b0;
    end
    stall_d = stall_q + 32'(id_valid && !id_ready);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      ex_q <= '0;
      ex_valid_q <= 1'b0;
      cnt_q <= '0;
      stall_q <= '0;
      sb_err_q <= 1'b0;
    end else begin
      ex_q <= ex_d;
      ex_valid_q <= ex_valid_d;
      cnt_q <= cnt_d;
      stall_q <= stall_d;
      sb_err_q <= sb_err_d;
    end
  end

  assign ex_valid = ex_valid_q;
  assign ex_opcode = ex_q.opcode;
  assign ex_twob = ex_q.twob;
  assign ex_regByte = ex_q.regb;
  assign ex_rmByte = ex_q.rmb;
  assign ex_mod = ex_q.md;
  assign ex_imm = ex_q.imm;
  assign ex_opA = ex_q.opa;
  assign ex_opB = ex_q.opb;
  assign ex_rsp = ex_q.rsp;
  assign ex_dest_mask = ex_q.dmask;
  assign stall_cycles = stall_q;
  assign sb_error = sb_err_q;

endmodule

// File: tb/tb_mod_operand_fetch.sv
// Directed bench for mod_operand_fetch: hazards, flush, reset,
// destination decode and stall accounting.
module tb_mod_operand_fetch;

  logic              clk = 1'b0;
  logic              reset;
  logic              id_valid;
  logic              id_ready;
  logic [7:0]        id_opcode;
  logic              id_twob;
  logic [3:0]        id_regByte;
  logic [3:0]        id_rmByte;
  logic [1:0]        id_mod;
  logic [63:0]       id_imm;
  logic [0:15][0:63] regfile;
  logic              wb_valid;
  logic [0:15]       wb_dest_mask;
  logic              flush;
  logic              ex_valid;
  logic              ex_ready;
  logic [7:0]        ex_opcode;
  logic              ex_twob;
  logic [3:0]        ex_regByte;
  logic [3:0]        ex_rmByte;
  logic [1:0]        ex_mod;
  logic [63:0]       ex_imm;
  logic [63:0]       ex_opA;
  logic [63:0]       ex_opB;
  logic [63:0]       ex_rsp;
  logic [0:15]       ex_dest_mask;
  logic [31:0]       stall_cycles;
  logic              sb_error;

  int n_asrt;
  int n_fail;

  mod_operand_fetch #(.CNT_W(2)) dut (
    .clk(clk), .reset(reset),
    .id_valid(id_valid), .id_ready(id_ready),
    .id_opcode(id_opcode), .id_twob(id_twob),
    .id_regByte(id_regByte), .id_rmByte(id_rmByte),
    .id_mod(id_mod), .id_imm(id_imm),
    .regfile(regfile),
    .wb_valid(wb_valid), .wb_dest_mask(wb_dest_mask),
    .flush(flush),
    .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_opcode(ex_opcode), .ex_twob(ex_twob),
    .ex_regByte(ex_regByte), .ex_rmByte(ex_rmByte),
    .ex_mod(ex_mod), .ex_imm(ex_imm),
    .ex_opA(ex_opA), .ex_opB(ex_opB), .ex_rsp(ex_rsp),
    .ex_dest_mask(ex_dest_mask),
    .stall_cycles(stall_cycles), .sb_error(sb_error)
  );

  always #5 clk = ~clk;

  logic [7:0]  d_op  [17] = '{8'hF7, 8'hAF, 8'hAF, 8'h05, 8'hE8,
                              8'h10, 8'h89, 8'h89, 8'h8B, 8'h8D,
                              8'h8D, 8'hBA, 8'h39, 8'h90, 8'h01,
                              8'h5F, 8'hC3};
  logic        d_tw  [17] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0,
                              1'b1, 1'b0, 1'b0, 1'b0, 1'b1,
                              1'b0, 1'b0, 1'b0, 1'b1, 1'b0,
                              1'b0, 1'b1};
  logic [1:0]  d_md  [17] = '{2'd3, 2'd3, 2'd3, 2'd3, 2'd3,
                              2'd3, 2'd3, 2'd1, 2'd3, 2'd3,
                              2'd1, 2'd3, 2'd3, 2'd3, 2'd3,
                              2'd3, 2'd3};
  // reg=6 -> 16'h0200, rm=9 -> 16'h0040 (bit 0 is the MSB)
  logic [15:0] d_exp [17] = '{16'hA000, 16'hA000, 16'h0040,
                              16'h8000, 16'h0800, 16'h0000,
                              16'h0040, 16'h0000, 16'h0200,
                              16'h0000, 16'h0200, 16'h0040,
                              16'h0000, 16'h0000, 16'h0040,
                              16'h0840, 16'h0800};

  function automatic logic [63:0] rv(input int i);
    return {8'(i * 17), 48'h0, 8'(i * 17)};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [7:0] op, input logic tw,
                       input logic [3:0] r, input logic [3:0] m,
                       input logic [1:0] md, input logic [63:0] imm);
    id_valid = 1'b1;
    id_opcode = op;
    id_twob = tw;
    id_regByte = r;
    id_rmByte = m;
    id_mod = md;
    id_imm = imm;
  endtask

  task automatic idle;
    id_valid = 1'b0;
  endtask

  task automatic retire(input logic [15:0] m);
    wb_valid = 1'b1;
    wb_dest_mask = m;
    tick;
    wb_valid = 1'b0;
  endtask

  initial begin
    n_asrt = 0;
    n_fail = 0;
    for (int i = 0; i < 16; i++) regfile[i] = rv(i);
    reset = 1'b0;
    ex_ready = 1'b1;
    flush = 1'b0;
    wb_valid = 1'b0;
    wb_dest_mask = '0;
    issue(8'h01, 1'b0, 4'd0, 4'd1, 2'd3, 64'h1);
    tick;
    tick;
    #1;
    chk("rst_id_ready", id_ready, 0);
    chk("rst_ex_valid", ex_valid, 0);
    chk("rst_ex_opcode", ex_opcode, 0);
    chk("rst_ex_opA", ex_opA, 0);
    chk("rst_ex_rsp", ex_rsp, 0);
    chk("rst_ex_imm", ex_imm, 0);
    chk("rst_ex_mask", ex_dest_mask, 0);
    chk("rst_stall", stall_cycles, 0);
    chk("rst_sb_error", sb_error, 0);

    reset = 1'b1;
    idle;
    tick;

    // Independent issue
    issue(8'h01, 1'b0, 4'd0, 4'd1, 2'd3, 64'h1234);
    #1 chk("ind_rdy1", id_ready, 1);
    tick;
    issue(8'h01, 1'b0, 4'd5, 4'd3, 2'd3, 64'hBEEF);
    #1;
    chk("ind_valid1", ex_valid, 1);
    chk("ind_op1", ex_opcode, 8'h01);
    chk("ind_opB1", ex_opB, rv(1));
    chk("ind_imm1", ex_imm, 64'h1234);
    chk("ind_mask1", ex_dest_mask, 16'h4000);
    chk("ind_rsp1", ex_rsp, rv(4));
    chk("ind_rdy2", id_ready, 1);
    tick;
    idle;
    #1;
    chk("ind_opA2", ex_opA, rv(5));
    chk("ind_opB2", ex_opB, rv(3));
    chk("ind_reg2", ex_regByte, 4'd5);
    chk("ind_mask2", ex_dest_mask, 16'h1000);
    chk("ind_imm2", ex_imm, 64'hBEEF);
    issue(8'h90, 1'b0, 4'd1, 4'd1, 2'd3, 64'h0);
    #1 chk("ind_haz1", id_ready, 0);
    tick;
    issue(8'h90, 1'b0, 4'd3, 4'd3, 2'd3, 64'h0);
    #1;
    chk("ind_haz3", id_ready, 0);
    chk("ind_drain", ex_valid, 0);
    tick;
    idle;
    retire(16'h5000);
    issue(8'h90, 1'b0, 4'd1, 4'd3, 2'd3, 64'h0);
    #1;
    chk("ind_free", id_ready, 1);
    chk("ind_stall", stall_cycles, 2);
    tick;
    idle;

    // RAW hazard on reg 2
    issue(8'h8B, 1'b0, 4'd2, 4'd7, 2'd3, 64'h0);
    #1 chk("raw_rdy0", id_ready, 1);
    tick;
    issue(8'h01, 1'b0, 4'd0, 4'd2, 2'd3, 64'h0);
    #1;
    chk("raw_stall", id_ready, 0);
    chk("raw_mask0", ex_dest_mask, 16'h2000);
    tick;
    tick;
    wb_valid = 1'b1;
    wb_dest_mask = 16'h2000;
    #1 chk("raw_wb_cycle", id_ready, 0);
    tick;
    wb_valid = 1'b0;
    #1;
    chk("raw_rdy", id_ready, 1);
    chk("raw_stalls", stall_cycles, 5);
    tick;
    idle;
    #1;
    chk("raw_opB", ex_opB, rv(2));
    chk("raw_mask1", ex_dest_mask, 16'h2000);
    retire(16'h2000);

    // Back-to-back pushes serialise on rsp
    issue(8'h50, 1'b0, 4'd0, 4'd0, 2'd3, 64'h0);
    #1 chk("psh_rdy", id_ready, 1);
    tick;
    #1;
    chk("psh_mask", ex_dest_mask, 16'h0800);
    chk("psh_rsp", ex_rsp, rv(4));
    chk("psh_haz", id_ready, 0);
    tick;
    wb_valid = 1'b1;
    wb_dest_mask = 16'h0800;
    #1 chk("psh_wbcyc", id_ready, 0);
    tick;
    wb_valid = 1'b0;
    #1 chk("psh_rdy2", id_ready, 1);
    tick;
    idle;
    retire(16'h0800);
    issue(8'h58, 1'b0, 4'd0, 4'd3, 2'd3, 64'h0);
    #1 chk("pop_rdy", id_ready, 1);
    tick;
    idle;
    #1;
    chk("pop_mask", ex_dest_mask, 16'h1800);
    chk("pop_stall", stall_cycles, 7);
    retire(16'h1800);

    // Destination decode table
    for (int k = 0; k < 17; k++) begin
      issue(d_op[k], d_tw[k], 4'd6, 4'd9, d_md[k], 64'h0);
      #1 chk($sformatf("dec%0d_rdy", k), id_ready, 1);
      tick;
      idle;
      #1 chk($sformatf("dec%0d_mask", k), ex_dest_mask, d_exp[k]);
      if (d_exp[k] != 16'h0) retire(d_exp[k]);
      else tick;
    end

    // Flush of a held instruction
    ex_ready = 1'b0;
    issue(8'hF7, 1'b0, 4'd6, 4'd9, 2'd3, 64'h0);
    #1 chk("fl_rdy", id_ready, 1);
    tick;
    idle;
    #1;
    chk("fl_valid", ex_valid, 1);
    chk("fl_mask", ex_dest_mask, 16'hA000);
    issue(8'h90, 1'b0, 4'd1, 4'd1, 2'd3, 64'h0);
    #1 chk("fl_block", id_ready, 0);
    tick;
    #1;
    chk("fl_hold_op", ex_opcode, 8'hF7);
    chk("fl_hold_v", ex_valid, 1);
    idle;
    flush = 1'b1;
    tick;
    flush = 1'b0;
    #1 chk("fl_clr", ex_valid, 0);
    issue(8'h90, 1'b0, 4'd0, 4'd2, 2'd3, 64'h0);
    #1 chk("fl_free", id_ready, 1);
    tick;
    idle;

    // Flush coinciding with accept
    flush = 1'b1;
    issue(8'hF7, 1'b0, 4'd6, 4'd9, 2'd3, 64'h0);
    #1 chk("fla_rdy0", id_ready, 1);
    tick;
    flush = 1'b0;
    idle;
    #1;
    chk("fla_valid0", ex_valid, 1);
    chk("fla_op0", ex_opcode, 8'hF7);
    flush = 1'b1;
    issue(8'h01, 1'b0, 4'd1, 4'd3, 2'd3, 64'h0);
    #1 chk("fla_rdy1", id_ready, 1);
    tick;
    flush = 1'b0;
    idle;
    #1;
    chk("fla_valid1", ex_valid, 1);
    chk("fla_op1", ex_opcode, 8'h01);
    chk("fla_mask1", ex_dest_mask, 16'h1000);
    ex_ready = 1'b1;
    issue(8'h90, 1'b0, 4'd0, 4'd2, 2'd3, 64'h0);
    #1 chk("fla_free", id_ready, 1);
    tick;
    idle;
    retire(16'h1000);
    #1 chk("fla_stall", stall_cycles, 8);

    // Retire and a dependent issue in the same cycle
    issue(8'h01, 1'b0, 4'd0, 4'd1, 2'd3, 64'h0);
    #1 chk("sim_rdy", id_ready, 1);
    tick;
    wb_valid = 1'b1;
    wb_dest_mask = 16'h4000;
    #1 chk("sim_haz", id_ready, 0);
    tick;
    wb_valid = 1'b0;
    #1;
    chk("sim_rdy2", id_ready, 1);
    chk("sim_stall", stall_cycles, 9);
    tick;
    idle;
    #1;
    chk("sim_err", sb_error, 0);
    chk("sim_mask", ex_dest_mask, 16'h4000);
    retire(16'h4000);
    #1 chk("sim_err2", sb_error, 0);

    // Reset mid-flight, then a stale retire
    issue(8'h8B, 1'b0, 4'd2, 4'd7, 2'd3, 64'h5);
    tick;
    issue(8'h01, 1'b0, 4'd0, 4'd2, 2'd3, 64'h0);
    reset = 1'b0;
    tick;
    #1;
    chk("mr_ready", id_ready, 0);
    chk("mr_valid", ex_valid, 0);
    chk("mr_op", ex_opcode, 0);
    chk("mr_imm", ex_imm, 0);
    chk("mr_opB", ex_opB, 0);
    chk("mr_mask", ex_dest_mask, 0);
    chk("mr_stall", stall_cycles, 0);
    reset = 1'b1;
    #1 chk("mr_free", id_ready, 1);
    idle;
    retire(16'h8000);
    #1;
    chk("mr_err", sb_error, 1);
    chk("mr_stall2", stall_cycles, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_asrt, n_fail);
    $finish;
  end

endmodule
